// File: rtl/jzjpcc_divide_sequencer.sv
// jzjpcc_divide_sequencer: 33-cycle restoring RV32M DIV/DIVU/REM/REMU controller with pipeline stall.
// Optional JZJPCC_DIV_FASTPATH_EN resolves divide-by-zero and signed overflow directly from IDLE.
module jzjpcc_divide_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        resultValid,
    output logic [31:0] result
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, dvs, rem_n, quo_n, q_fin, r_fin, fast_res;
    logic [32:0] r_sh, diff;
    logic        qneg, rneg, op_rem, is_signed, a_neg, b_neg, no_borrow, fast;
    logic        unused;
    assign unused      = funct3[2];
    assign is_signed   = !funct3[0];
    assign a_neg       = is_signed && dividend[31];
    assign b_neg       = is_signed && divisor[31];
    assign busy        = state != IDLE;
    assign resultValid = state == DONE;
    assign stall       = !flush && ((state == IDLE && start) || state == RUN);
    // The remainder stays below the divisor, so bit 32 of the trial difference is a clean borrow flag.
    assign r_sh      = {rem, quo[31]};
    assign diff      = r_sh - {1'b0, dvs};
    assign no_borrow = !diff[32];
    assign rem_n     = no_borrow ? diff[31:0] : r_sh[31:0];
    assign quo_n     = {quo[30:0], no_borrow};
    assign q_fin     = (qneg && dvs != 32'd0) ? -quo_n : quo_n;
    assign r_fin     = rneg ? -rem_n : rem_n;
    assign fast_res  = funct3[1] ? (divisor == 32'd0 ? dividend : 32'd0)
                                 : (divisor == 32'd0 ? 32'hFFFF_FFFF : 32'h8000_0000);
`ifdef JZJPCC_DIV_FASTPATH_EN
    assign fast = divisor == 32'd0 || (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF);
`else
    assign fast = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvs    <= 32'd0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            op_rem <= 1'b0;
            result <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_rem <= funct3[1];
                    rem    <= 32'd0;
                    quo    <= a_neg ? -dividend : dividend;
                    dvs    <= b_neg ? -divisor : divisor;
                    qneg   <= a_neg ^ b_neg;
                    rneg   <= a_neg;
                    cnt    <= 5'd0;
                    state  <= fast ? DONE : RUN;
                    if (fast) result <= fast_res;
                end
                RUN: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= op_rem ? r_fin : q_fin;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jzjpcc_divide_sequencer.sv
// tb_jzjpcc_divide_sequencer: directed-vector bench for the RV32M divide sequencer.
module tb_jzjpcc_divide_sequencer;
`ifdef JZJPCC_DIV_FASTPATH_EN
    localparam int EDGE_LAT = 1;
`else
    localparam int EDGE_LAT = 33;
`endif
    logic        clock, reset, start, flush, stall, busy, resultValid;
    logic [2:0]  funct3;
    logic [31:0] dividend, divisor, result;
    int          n_vec, n_bad;

    jzjpcc_divide_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .dividend(dividend), .divisor(divisor), .flush(flush), .stall(stall),
        .busy(busy), .resultValid(resultValid), .result(result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int st, output logic [31:0] res);
        start = 1'b1; funct3 = f; dividend = a; divisor = b;
        #1;
        st  = int'(stall);
        lat = 0;
        do begin
            @(negedge clock); start = 1'b0; #1;
            lat++;
            st += int'(stall);
        end while (!resultValid && lat < 80);
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b101; dividend = 0; divisor = 0;
        repeat (2) @(negedge clock);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (resultValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", resultValid); end
        n_vec++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_divu();
        int lat, st; logic [31:0] res;
        @(negedge clock); run_op(3'b101, 32'd100, 32'd7, lat, st, res);
        n_vec++; if (lat !== 33) begin n_bad++; $display("FAIL divu_latency got %0d want 33", lat); end
        n_vec++; if (st !== 33) begin n_bad++; $display("FAIL divu_stall_cycles got %0d want 33", st); end
        n_vec++; if (res !== 32'd14) begin n_bad++; $display("FAIL divu_100_7 got %h want %h", res, 32'd14); end
        @(negedge clock); run_op(3'b111, 32'd100, 32'd7, lat, st, res);
        n_vec++; if (res !== 32'd2) begin n_bad++; $display("FAIL remu_100_7 got %h want %h", res, 32'd2); end
        @(negedge clock); run_op(3'b101, 32'hFFFF_FFFF, 32'h10, lat, st, res);
        n_vec++; if (res !== 32'h0FFF_FFFF) begin n_bad++; $display("FAIL divu_big got %h want 0fffffff", res); end
    endtask

    task automatic test_signed();
        logic [2:0]  f[4] = '{3'b100, 3'b110, 3'b110, 3'b100};
        logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] b[4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] e[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
        int lat, st; logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); run_op(f[i], a[i], b[i], lat, st, res);
            n_vec++; if (res !== e[i]) begin n_bad++; $display("FAIL signed_%0d got %h want %h", i, res, e[i]); end
        end
    endtask

    task automatic test_edge();
        logic [2:0]  f[6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b101};
        logic [31:0] a[6] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[6] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e[6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0};
        int          l[6] = '{EDGE_LAT, EDGE_LAT, EDGE_LAT, EDGE_LAT, EDGE_LAT, 33};
        int lat, st; logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); run_op(f[i], a[i], b[i], lat, st, res);
            n_vec++; if (res !== e[i]) begin n_bad++; $display("FAIL edge_%0d_result got %h want %h", i, res, e[i]); end
            n_vec++; if (lat !== l[i]) begin n_bad++; $display("FAIL edge_%0d_latency got %0d want %0d", i, lat, l[i]); end
            n_vec++; if (st !== l[i]) begin n_bad++; $display("FAIL edge_%0d_stall_cycles got %0d want %0d", i, st, l[i]); end
        end
    endtask

    task automatic test_flush();
        int lat, st, rv; logic [31:0] res;
        @(negedge clock); run_op(3'b101, 32'd100, 32'd7, lat, st, res);
        @(negedge clock); start = 1'b1; funct3 = 3'b101; dividend = 32'd50; divisor = 32'd5;
        #1; rv = int'(resultValid);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock); start = 1'b0; #1;
            rv += int'(resultValid);
        end
        @(negedge clock); flush = 1'b1; #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", busy); end
        rv += int'(resultValid);
        @(negedge clock); flush = 1'b0; #1;
        rv += int'(resultValid);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle got busy=%b want 0", busy); end
        n_vec++; if (rv !== 0) begin n_bad++; $display("FAIL flush_no_valid got %0d pulses want 0", rv); end
        n_vec++; if (result !== 32'd14) begin n_bad++; $display("FAIL flush_result_kept got %h want %h", result, 32'd14); end
        run_op(3'b101, 32'd1000, 32'd10, lat, st, res);
        n_vec++; if (lat !== 33) begin n_bad++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
        n_vec++; if (res !== 32'd100) begin n_bad++; $display("FAIL flush_restart_result got %h want %h", res, 32'd100); end
    endtask

    task automatic test_back_to_back();
        int first, pulses, lat2;
        @(negedge clock); start = 1'b1; funct3 = 3'b101; dividend = 32'd100; divisor = 32'd7;
        first = -1; pulses = 0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clock); #1;
            if (resultValid) begin pulses++; if (first < 0) first = i; end
        end
        n_vec++; if (first !== 33) begin n_bad++; $display("FAIL b2b_first_valid got %0d want 33", first); end
        n_vec++; if (result !== 32'd14) begin n_bad++; $display("FAIL b2b_first_result got %h want %h", result, 32'd14); end
        @(negedge clock); funct3 = 3'b111; #1;
        pulses += int'(resultValid);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_stall got %b want 1", stall); end
        lat2 = 0;
        do begin
            @(negedge clock); start = 1'b0; #1;
            lat2++;
        end while (!resultValid && lat2 < 80);
        n_vec++; if (pulses !== 1) begin n_bad++; $display("FAIL b2b_single_pulse got %0d want 1", pulses); end
        n_vec++; if (lat2 !== 33) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 33", lat2); end
        n_vec++; if (result !== 32'd2) begin n_bad++; $display("FAIL b2b_second_result got %h want %h", result, 32'd2); end
    endtask

    task automatic test_async_reset();
        int lat, st; logic [31:0] res;
        @(negedge clock); start = 1'b1; funct3 = 3'b101; dividend = 32'd1000; divisor = 32'd3;
        for (int i = 1; i <= 15; i++) begin @(negedge clock); start = 1'b0; end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL areset_stall got %b want 0", stall); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy got %b want 0", busy); end
        n_vec++; if (resultValid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b want 0", resultValid); end
        n_vec++; if (result !== 32'd0) begin n_bad++; $display("FAIL areset_result got %h want 0", result); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock); run_op(3'b100, 32'hFFFF_FF9C, 32'd7, lat, st, res);
        n_vec++; if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL areset_after got %h want fffffff2", res); end
        n_vec++; if (lat !== 33) begin n_bad++; $display("FAIL areset_after_latency got %0d want 33", lat); end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        test_reset();
        test_divu();
        test_signed();
        test_edge();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
